// File: rtl/mul_iter_chunked.sv
// Iterative chunk-decomposed multiplier: one CHUNK x CHUNK partial product per clock,
// accumulated into a 2*WIDTH register, with signed/unsigned mode and valid/ready on both sides.
module mul_iter_chunked #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int unsigned M  = WIDTH / CHUNK;
   localparam int unsigned N  = M * M;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KLast = KW'(N - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_mag_q, a_mag_d;
   logic [WIDTH-1:0]  b_mag_q, b_mag_d;
   logic              neg_q, neg_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [KW-1:0]     k_q, k_d;
   logic [PW-1:0]     product_q, product_d;

   int unsigned       idx_i, idx_j;
   logic [CHUNK-1:0]  a_sl, b_sl;
   logic [2*CHUNK-1:0] pp;
   logic [PW-1:0]     pp_sh;
   logic [PW-1:0]     acc_sum;

   // Slice pair selected by k: i walks slices of a, j walks slices of b.
   always_comb begin
      idx_i   = 32'(k_q) / M;
      idx_j   = 32'(k_q) % M;
      a_sl    = CHUNK'(a_mag_q >> (idx_i * CHUNK));
      b_sl    = CHUNK'(b_mag_q >> (idx_j * CHUNK));
      pp      = {{CHUNK{1'b0}}, a_sl} * {{CHUNK{1'b0}}, b_sl};
      pp_sh   = PW'(pp) << ((idx_i + idx_j) * CHUNK);
      acc_sum = acc_q + pp_sh;
   end

   always_comb begin
      state_d   = state_q;
      a_mag_d   = a_mag_q;
      b_mag_d   = b_mag_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      k_d       = k_q;
      product_d = product_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               // Magnitudes are unsigned, so the most negative input becomes 2^(WIDTH-1).
               a_mag_d = (signed_mode && a[WIDTH-1]) ? -a : a;
               b_mag_d = (signed_mode && b[WIDTH-1]) ? -b : b;
               neg_d   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_d   = '0;
               k_d     = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            acc_d = acc_sum;
            k_d   = k_q + KW'(1);
            if (k_q == KLast) begin
               product_d = neg_q ? -acc_sum : acc_sum;
               state_d   = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         k_q       <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_mag_q   <= a_mag_d;
         b_mag_q   <= b_mag_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         k_q       <= k_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign product   = product_q;

endmodule
